// File: rtl/axc_axil_pkg.sv
// Shared definitions for the AXI4-Lite approximate adder peripheral:
// register map, control/status bit positions, mode and operation-state enums.
package axc_axil_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_STATUS = 5'h04;
  localparam logic [4:0] OFF_OPA    = 5'h08;
  localparam logic [4:0] OFF_OPB    = 5'h0C;
  localparam logic [4:0] OFF_SUM    = 5'h10;
  localparam logic [4:0] OFF_ERR    = 5'h14;
  localparam logic [4:0] OFF_CNT    = 5'h18;
  localparam logic [4:0] OFF_RSVD   = 5'h1C;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_MODE    = 1;
  localparam int unsigned CTRL_CNT_CLR = 2;
  localparam int unsigned CTRL_IE      = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_COUT = 2;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_BUSY = 2'd1,
    OP_DONE = 2'd2
  } op_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) r[i*8 +: 8] = data[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axc_seg_adder_pipe.sv
// Segmented adder: exact and carry-broken approximate sums computed side by
// side, selected by mode, then delayed through PIPE register stages.
module axc_seg_adder_pipe
  import axc_axil_pkg::*;
#(
  parameter int OP_W  = 16,
  parameter int BLK_W = 4,
  parameter int PIPE  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  mode_e           mode,
  input  logic            valid_in,
  output logic [OP_W-1:0] sum,
  output logic            cout,
  output logic [OP_W:0]   err,
  output logic            valid_out
);

  logic [OP_W:0] exact_s;
  logic [OP_W:0] approx_s;
  logic [OP_W:0] res_d;
  logic [OP_W:0] err_d;
  logic          carry;

  always_comb begin
    exact_s  = {1'b0, a} + {1'b0, b};
    approx_s = '0;
    carry    = 1'b0;
    // Carry is dropped at every segment boundary; a narrower top segment
    // falls out naturally from the loop bound.
    for (int unsigned i = 0; i < OP_W; i++) begin
      if (i % BLK_W == 0) carry = 1'b0;
      approx_s[i] = a[i] ^ b[i] ^ carry;
      carry       = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    approx_s[OP_W] = carry;
    if (mode == MODE_APPROX) begin
      res_d = approx_s;
      err_d = exact_s - approx_s;
    end else begin
      res_d = exact_s;
      err_d = '0;
    end
  end

  logic [OP_W:0]   res_q [PIPE];
  logic [OP_W:0]   err_q [PIPE];
  logic [PIPE-1:0] vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PIPE; i++) begin
        res_q[i] <= '0;
        err_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      res_q[0] <= res_d;
      err_q[0] <= err_d;
      vld_q[0] <= valid_in;
      for (int unsigned i = 1; i < PIPE; i++) begin
        res_q[i] <= res_q[i-1];
        err_q[i] <= err_q[i-1];
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign sum       = res_q[PIPE-1][OP_W-1:0];
  assign cout      = res_q[PIPE-1][OP_W];
  assign err       = err_q[PIPE-1];
  assign valid_out = vld_q[PIPE-1];

endmodule

// File: rtl/axc_adder_axil.sv
// AXI4-Lite register front end for the segmented approximate adder, with
// run-time exact/approx mode, error reporting and an operation counter.
module axc_adder_axil
  import axc_axil_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5,
  parameter int OP_W                 = 16,
  parameter int BLK_W                = 4,
  parameter int PIPE                 = 2
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [(C_S00_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic                                irq
);

  logic            bvalid_q, bvalid_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d, rd_word;
  logic [OP_W-1:0] opa_q, opa_d, opb_q, opb_d;
  mode_e           mode_q, mode_d;
  logic            ie_q, ie_d;
  op_state_e       op_state_q, op_state_d;
  logic [OP_W:0]   sum_q, sum_d, err_q, err_d;
  logic [31:0]     cnt_q, cnt_d;

  logic            wr_fire, rd_fire, ctrl_wr, start_fire;
  logic [4:0]      wr_off, rd_off;
  logic [31:0]     opa_wr, opb_wr;
  logic [OP_W-1:0] pipe_sum;
  logic [OP_W:0]   pipe_err;
  logic            pipe_cout, pipe_valid;

  assign wr_fire = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
  assign rd_fire = s00_axi_arvalid & ~rvalid_q;
  assign wr_off  = {s00_axi_awaddr[4:2], 2'b00};
  assign rd_off  = {s00_axi_araddr[4:2], 2'b00};

  assign s00_axi_awready = wr_fire;
  assign s00_axi_wready  = wr_fire;
  assign s00_axi_arready = rd_fire;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign irq             = (op_state_q == OP_DONE) & ie_q;

  assign ctrl_wr    = wr_fire && (wr_off == OFF_CTRL) && s00_axi_wstrb[0];
  assign start_fire = ctrl_wr && s00_axi_wdata[CTRL_START] && (op_state_q != OP_BUSY);
  assign opa_wr     = apply_wstrb(32'(opa_q), s00_axi_wdata, s00_axi_wstrb);
  assign opb_wr     = apply_wstrb(32'(opb_q), s00_axi_wdata, s00_axi_wstrb);

  // Operands come straight from the registers and mode from the START write,
  // so the first pipe stage is the operation's latch and later writes cannot
  // disturb it.
  axc_seg_adder_pipe #(
    .OP_W (OP_W),
    .BLK_W(BLK_W),
    .PIPE (PIPE)
  ) u_pipe (
    .clk      (s00_axi_aclk),
    .rst_n    (s00_axi_aresetn),
    .a        (opa_q),
    .b        (opb_q),
    .mode     (mode_e'(s00_axi_wdata[CTRL_MODE])),
    .valid_in (start_fire),
    .sum      (pipe_sum),
    .cout     (pipe_cout),
    .err      (pipe_err),
    .valid_out(pipe_valid)
  );

  always_comb begin
    opa_d      = opa_q;
    opb_d      = opb_q;
    mode_d     = mode_q;
    ie_d       = ie_q;
    op_state_d = op_state_q;
    sum_d      = sum_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if (wr_fire) begin
      case (wr_off)
        OFF_CTRL: if (s00_axi_wstrb[0]) begin
          mode_d = mode_e'(s00_axi_wdata[CTRL_MODE]);
          ie_d   = s00_axi_wdata[CTRL_IE];
        end
        OFF_OPA: opa_d = opa_wr[OP_W-1:0];
        OFF_OPB: opb_d = opb_wr[OP_W-1:0];
        default: ;
      endcase
    end
    if (start_fire) op_state_d = OP_BUSY;
    if (pipe_valid) begin
      op_state_d = OP_DONE;
      sum_d      = {pipe_cout, pipe_sum};
      err_d      = pipe_err;
      cnt_d      = cnt_q + 32'd1;
    end
    if (ctrl_wr && s00_axi_wdata[CTRL_CNT_CLR]) cnt_d = '0;
  end

  always_comb begin
    rd_word = '0;
    case (rd_off)
      OFF_CTRL: begin
        rd_word[CTRL_MODE] = (mode_q == MODE_APPROX);
        rd_word[CTRL_IE]   = ie_q;
      end
      OFF_STATUS: begin
        rd_word[STAT_BUSY] = (op_state_q == OP_BUSY);
        rd_word[STAT_DONE] = (op_state_q == OP_DONE);
        rd_word[STAT_COUT] = sum_q[OP_W];
      end
      OFF_OPA:  rd_word[OP_W-1:0] = opa_q;
      OFF_OPB:  rd_word[OP_W-1:0] = opb_q;
      OFF_SUM:  rd_word[OP_W:0]   = sum_q;
      OFF_ERR:  rd_word[OP_W:0]   = err_q;
      OFF_CNT:  rd_word           = cnt_q;
      OFF_RSVD: rd_word           = '0;
      default:  rd_word           = '0;
    endcase
  end

  always_comb begin
    bvalid_d = bvalid_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (wr_fire)             bvalid_d = 1'b1;
    else if (s00_axi_bready) bvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end else if (s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      mode_q     <= MODE_EXACT;
      ie_q       <= 1'b0;
      op_state_q <= OP_IDLE;
      sum_q      <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
    end else begin
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      mode_q     <= mode_d;
      ie_q       <= ie_d;
      op_state_q <= op_state_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                       s00_axi_araddr[1:0], opa_wr[31:OP_W], opb_wr[31:OP_W]};

endmodule

// File: tb/tb_axc_adder_axil.sv
// Directed bench for axc_adder_axil: reads push expectations into a queue,
// an independent read-channel monitor pops and compares them.
module tb_axc_adder_axil;

  localparam int OP_W  = 16;
  localparam int BLK_W = 4;
  localparam int PIPE  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        irq;

  axc_adder_axil #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(5),
    .OP_W (OP_W),
    .BLK_W(BLK_W),
    .PIPE (PIPE)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [31:0] mon_exp;
  string       mon_name;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read: got 0x%08h, expected no response", rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, rdata, mon_exp);
        check({mon_name, "_rresp"}, 32'(rresp), 32'h0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int t = 0;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (awready !== 1'b1 && t < 40) begin
      @(posedge clk); #2;
      t++;
    end
    if (awready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL aw_timeout: awready=%b, expected 1 within 40 cycles", awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input string nm);
    int t = 0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    #1;
    while (arready !== 1'b1 && t < 40) begin
      @(posedge clk); #2;
      t++;
    end
    if (arready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ar_timeout_%s: arready=%b, expected 1 within 40 cycles", nm, arready);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [4:0] off;

    // Reset state
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_bvalid", 32'(bvalid), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      off = 5'(i * 4);
      axi_read(off, 32'h0, $sformatf("rst_off_%02h", off));
    end

    // Exact 0x00FF + 0x0001; first read lands on the completion edge
    axi_write(5'h08, 32'h0000_00FF, 4'hF);
    axi_write(5'h0C, 32'h0000_0001, 4'hF);
    axi_write(5'h00, 32'h0000_0001, 4'hF);
    axi_read(5'h04, 32'h0000_0001, "ex_status_at_completion");
    axi_read(5'h04, 32'h0000_0002, "ex_status_done");
    axi_read(5'h10, 32'h0000_0100, "ex_sum");
    axi_read(5'h14, 32'h0000_0000, "ex_err");
    axi_read(5'h18, 32'h0000_0001, "ex_cnt");
    axi_read(5'h00, 32'h0000_0000, "ex_ctrl");

    // Approx, same operands
    axi_write(5'h00, 32'h0000_0003, 4'hF);
    tick(4);
    check("ap_irq_ie_off", 32'(irq), 32'h0);
    axi_read(5'h10, 32'h0000_00F0, "ap_sum");
    axi_read(5'h14, 32'h0000_0010, "ap_err");
    axi_read(5'h04, 32'h0000_0002, "ap_status");
    axi_read(5'h00, 32'h0000_0002, "ap_ctrl");
    axi_read(5'h18, 32'h0000_0002, "ap_cnt");

    // Carry-out: exact then approx
    axi_write(5'h08, 32'h0000_FFFF, 4'hF);
    axi_write(5'h00, 32'h0000_0001, 4'hF);
    tick(4);
    axi_read(5'h10, 32'h0001_0000, "co_ex_sum");
    axi_read(5'h14, 32'h0000_0000, "co_ex_err");
    axi_read(5'h04, 32'h0000_0006, "co_ex_status");
    axi_write(5'h00, 32'h0000_0003, 4'hF);
    tick(4);
    axi_read(5'h10, 32'h0000_FFF0, "co_ap_sum");
    axi_read(5'h14, 32'h0000_0010, "co_ap_err");
    axi_read(5'h04, 32'h0000_0002, "co_ap_status");
    axi_read(5'h18, 32'h0000_0004, "co_cnt");

    // Interrupt enable with DONE already set
    axi_write(5'h00, 32'h0000_000A, 4'hF);
    check("irq_on", 32'(irq), 32'h1);
    axi_read(5'h00, 32'h0000_000A, "irq_ctrl");
    axi_write(5'h00, 32'h0000_0002, 4'hF);
    check("irq_off", 32'(irq), 32'h0);

    // Second START on the completion edge is ignored; OPA rewritten after
    axi_write(5'h08, 32'h0000_0003, 4'hF);
    axi_write(5'h0C, 32'h0000_0005, 4'hF);
    axi_write(5'h00, 32'h0000_0001, 4'hF);
    axi_write(5'h00, 32'h0000_0001, 4'hF);
    axi_write(5'h08, 32'h0000_0100, 4'hF);
    tick(6);
    axi_read(5'h10, 32'h0000_0008, "busy_sum");
    axi_read(5'h18, 32'h0000_0005, "busy_cnt");
    axi_read(5'h08, 32'h0000_0100, "busy_opa");
    axi_read(5'h04, 32'h0000_0002, "busy_status");

    // CNT_CLR on the completion edge: clear wins
    axi_write(5'h00, 32'h0000_0001, 4'hF);
    axi_write(5'h00, 32'h0000_0004, 4'hF);
    tick(4);
    axi_read(5'h18, 32'h0000_0000, "clr_cnt");
    axi_read(5'h10, 32'h0000_0105, "clr_sum");
    axi_read(5'h04, 32'h0000_0002, "clr_status");

    // Writes to read-only and reserved offsets are ignored
    axi_write(5'h10, 32'hFFFF_FFFF, 4'hF);
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF);
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h10, 32'h0000_0105, "ro_sum");
    axi_read(5'h1C, 32'h0000_0000, "ro_rsvd");
    axi_read(5'h18, 32'h0000_0000, "ro_cnt");

    // Back-pressure on B plus a byte-strobed write waiting behind it
    bready = 1'b0;
    axi_write(5'h08, 32'h0000_1234, 4'hF);
    awaddr = 5'h08; wdata = 32'h0000_FFFF; wstrb = 4'b0001;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_bvalid_%0d", i), 32'(bvalid), 32'h1);
      check($sformatf("bp_awready_%0d", i), 32'(awready), 32'h0);
      @(posedge clk); #2;
    end
    check("bp_bresp", 32'(bresp), 32'h0);
    bready = 1'b1;
    t = 0;
    while (awready !== 1'b1 && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    check("bp_aw_accept", 32'(awready), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    axi_read(5'h08, 32'h0000_12FF, "wstrb_opa");

    // Reset during BUSY aborts the operation
    axi_write(5'h0C, 32'h0000_0001, 4'hF);
    axi_write(5'h00, 32'h0000_0001, 4'hF);
    tick(4);
    axi_read(5'h10, 32'h0000_1300, "pre_rst_sum");
    axi_read(5'h18, 32'h0000_0001, "pre_rst_cnt");
    axi_write(5'h00, 32'h0000_0009, 4'hF);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("abort_irq", 32'(irq), 32'h0);
    axi_read(5'h04, 32'h0000_0000, "abort_status");
    axi_read(5'h18, 32'h0000_0000, "abort_cnt");
    axi_read(5'h10, 32'h0000_0000, "abort_sum");
    axi_read(5'h08, 32'h0000_0000, "abort_opa");

    tick(4);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pending_reads: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
